// File: rtl/en_pkg.sv
// Shared types and JPEG byte constants for the entropy-coder back end.
package en_pkg;

  typedef enum logic [2:0] {
    RUN, STUFF, PAD, STUFF2, FIN, EOI0, EOI1
  } bp_state_t;

  localparam logic [7:0]  JPEG_STUFF_BYTE = 8'h00;
  localparam logic [7:0]  JPEG_FF         = 8'hFF;
  localparam logic [15:0] JPEG_EOI        = 16'hFFD9;
  localparam int          HUFF_W_MAX      = 16;

endpackage

// File: rtl/en_bitmask.sv
// Left-aligned mask: the top `len` bits of a W-bit word are set, the rest clear.
module en_bitmask #(
  parameter int W  = 8,
  parameter int LW = $clog2(W + 1)
) (
  input  logic [LW-1:0] len,
  output logic [W-1:0]  mask
);

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_bit
      assign mask[W-1-i] = (len > LW'(i));
    end
  endgenerate

endmodule

// File: rtl/en_bitpack.sv
// JPEG scan bit packer: merges Huffman + magnitude codes MSB-first, stuffs 0x00
// after 0xFF, pads the final byte with 1s. Define EN_BITPACK_EOI_EN to append FFD9.
module en_bitpack
  import en_pkg::*;
#(
  parameter int BUF_W  = 32,
  parameter int HUFF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HUFF_W-1:0] in_huff,
  input  logic [4:0]        in_hlen,
  input  logic [7:0]        in_magn,
  input  logic [3:0]        in_ssss,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              done
);

  localparam int CW = $clog2(BUF_W + 1);

`ifdef EN_BITPACK_EOI_EN
  localparam bp_state_t END_ST = EOI0;
`else
  localparam bp_state_t END_ST = FIN;
`endif

  bp_state_t         state, state_nx;
  logic [BUF_W-1:0]  bit_buf;
  logic [CW-1:0]     cnt;
  logic              last_pend;

  logic [HUFF_W-1:0] hmask;
  logic [7:0]        mmask, pmask, top;
  logic [BUF_W-1:0]  seg_h, seg_m;
  logic [CW-1:0]     mpos, seg_len;
  logic              acc, emit;

  en_bitmask #(.W(HUFF_W), .LW(5)) u_hmask (.len(in_hlen), .mask(hmask));
  en_bitmask #(.W(8),      .LW(4)) u_mmask (.len(in_ssss), .mask(mmask));
  en_bitmask #(.W(8),      .LW(4)) u_pmask (.len({1'b0, cnt[2:0]}), .mask(pmask));

  // Buffer bits below cnt are always zero, so new bits can simply be OR-ed in.
  assign mpos    = cnt + CW'(in_hlen);
  assign seg_len = CW'(in_hlen) + CW'(in_ssss);
  assign seg_h   = {in_huff & hmask, {(BUF_W-HUFF_W){1'b0}}} >> cnt;
  assign seg_m   = {in_magn & mmask, {(BUF_W-8){1'b0}}} >> mpos;
  assign top     = bit_buf[BUF_W-1 -: 8];
  assign acc     = in_valid && in_ready;
  assign emit    = out_valid && out_ready;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = JPEG_STUFF_BYTE;
    done      = 1'b0;
    case (state)
      RUN: begin
        in_ready  = (cnt < CW'(8)) && !last_pend;
        out_valid = (cnt >= CW'(8));
        out_byte  = top;
        if (out_valid && out_ready && top == JPEG_FF) state_nx = STUFF;
        else if (last_pend && cnt < CW'(8))           state_nx = PAD;
      end
      STUFF: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = (last_pend && cnt < CW'(8)) ? PAD : RUN;
      end
      PAD: begin
        if (cnt == '0) state_nx = END_ST;
        else begin
          out_valid = 1'b1;
          out_byte  = top | ~pmask;
          if (out_ready) state_nx = ((top | ~pmask) == JPEG_FF) ? STUFF2 : END_ST;
        end
      end
      STUFF2: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = END_ST;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = RUN;
      end
`ifdef EN_BITPACK_EOI_EN
      EOI0: begin
        out_valid = 1'b1;
        out_byte  = JPEG_EOI[15:8];
        if (out_ready) state_nx = EOI1;
      end
      EOI1: begin
        out_valid = 1'b1;
        out_byte  = JPEG_EOI[7:0];
        if (out_ready) state_nx = FIN;
      end
`endif
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      bit_buf   <= '0;
      cnt       <= '0;
      last_pend <= 1'b0;
    end else begin
      state <= state_nx;
      // Accept (cnt<8) and RUN emit (cnt>=8) are mutually exclusive.
      if (acc) begin
        bit_buf <= bit_buf | seg_h | seg_m;
        cnt     <= cnt + seg_len;
        if (in_last) last_pend <= 1'b1;
      end
      if (state == RUN && emit) begin
        bit_buf <= bit_buf << 8;
        cnt     <= cnt - CW'(8);
      end
      if (state == PAD && emit) begin
        bit_buf <= '0;
        cnt     <= '0;
      end
      if (state == FIN) begin
        bit_buf   <= '0;
        cnt       <= '0;
        last_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_en_bitpack.sv
// Scoreboard bench for en_bitpack: a bit-queue model predicts the byte stream.
module tb_en_bitpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_huff;
  logic [4:0]  in_hlen;
  logic [7:0]  in_magn;
  logic [3:0]  in_ssss;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        done;

  en_bitpack #(.BUF_W(32), .HUFF_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_huff(in_huff), .in_hlen(in_hlen), .in_magn(in_magn), .in_ssss(in_ssss),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .done(done)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         byte_cnt = 0;
  int         exp_done = 0;
  logic [7:0] exp_q[$];
  bit         bq[$];
  bit         bp_stop;

`ifdef EN_BITPACK_EOI_EN
  localparam int EOI_BYTES = 2;
`else
  localparam int EOI_BYTES = 0;
`endif

  function automatic void push_b(input logic [7:0] b);
    exp_q.push_back(b);
    if (b == 8'hFF) exp_q.push_back(8'h00);
  endfunction

  function automatic void model_sym(input logic [15:0] h, input logic [4:0] hl,
                                    input logic [7:0] m, input logic [3:0] s, input bit l);
    logic [7:0] b;
    for (int i = 0; i < int'(hl); i++) bq.push_back(h[15-i]);
    for (int i = 0; i < int'(s); i++)  bq.push_back(m[7-i]);
    while (bq.size() >= 8) begin
      for (int i = 0; i < 8; i++) b[7-i] = bq.pop_front();
      push_b(b);
    end
    if (l) begin
      if (bq.size() > 0) begin
        b = 8'hFF;
        for (int i = 0; bq.size() > 0; i++) b[7-i] = bq.pop_front();
        push_b(b);
      end
`ifdef EN_BITPACK_EOI_EN
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hD9);
`endif
      exp_done++;
    end
  endfunction

  // Compares every output handshake and done pulse against the scoreboard.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          n_tests++;
          byte_cnt++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_byte: unexpected byte %02h, required none", out_byte);
          end else begin
            e = exp_q.pop_front();
            if (out_byte !== e) begin
              n_fail++;
              $display("FAIL out_byte: got %02h, required %02h", out_byte, e);
            end
          end
        end
        if (done) begin
          n_tests++;
          if (exp_done == 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done: pulse with %0d dones, %0d bytes outstanding, required 1 and 0",
                     exp_done, exp_q.size());
          end else exp_done--;
        end
      end
    end
  endtask

  task automatic send(input logic [15:0] h, input logic [4:0] hl,
                      input logic [7:0] m, input logic [3:0] s, input bit l);
    int t = 0;
    in_valid = 1'b1; in_huff = h; in_hlen = hl; in_magn = m; in_ssss = s; in_last = l;
    @(negedge clk);
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send: in_ready timeout, got 0, required 1");
    end else model_sym(h, hl, m, s, l);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || exp_done != 0) && t < 3000) begin @(negedge clk); t++; end
    n_tests++;
    if (exp_q.size() != 0 || exp_done != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d bytes and %0d dones outstanding, required 0 and 0",
               name, exp_q.size(), exp_done);
      exp_q.delete(); exp_done = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_huff = '0; in_hlen = '0; in_magn = '0; in_ssss = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests += 4;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
    if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset out_byte: got %02h, required 00", out_byte); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL reset done: got %b, required 0", done); end
  endtask

  task automatic test_exact_byte();
    int b0 = byte_cnt;
    send(16'hA000, 5'd3, 8'hC0, 4'd2, 1'b0);
    send(16'h0000, 5'd3, 8'h00, 4'd0, 1'b1);
    drain("exact_byte");
    n_tests += 2;
    if (byte_cnt - b0 != 1 + EOI_BYTES) begin
      n_fail++;
      $display("FAIL exact_byte count: got %0d bytes, required %0d", byte_cnt - b0, 1 + EOI_BYTES);
    end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL exact_byte idle out_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_stuff_then_pad();
    send(16'hFF00, 5'd8, 8'h00, 4'd0, 1'b0);
    send(16'h4000, 5'd3, 8'h00, 4'd0, 1'b1);
    drain("stuff_then_pad");
  endtask

  task automatic test_pad_to_ff();
    int b0 = byte_cnt;
    send(16'hF800, 5'd5, 8'h00, 4'd0, 1'b1);
    drain("pad_to_ff");
    n_tests++;
    if (byte_cnt - b0 != 2 + EOI_BYTES) begin
      n_fail++;
      $display("FAIL pad_to_ff count: got %0d bytes, required %0d", byte_cnt - b0, 2 + EOI_BYTES);
    end
  endtask

  task automatic test_empty_scan();
    int b0 = byte_cnt;
    send(16'hFFFF, 5'd0, 8'hFF, 4'd0, 1'b1);
    drain("empty_scan");
    n_tests++;
    if (byte_cnt - b0 != EOI_BYTES) begin
      n_fail++;
      $display("FAIL empty_scan count: got %0d bytes, required %0d", byte_cnt - b0, EOI_BYTES);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(16'hABCD, 5'd16, 8'h5A, 4'd8, 1'b0);
    repeat (5) begin
      @(negedge clk);
      n_tests += 2;
      if (out_valid !== 1'b1 || out_byte !== 8'hAB) begin
        n_fail++;
        $display("FAIL backpressure hold: got valid=%b byte=%02h, required 1 AB", out_valid, out_byte);
      end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure in_ready: got %b, required 0", in_ready); end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(16'h0000, 5'd0, 8'h00, 4'd0, 1'b1);
    drain("backpressure");
  endtask

  task automatic test_max_symbol_random();
    int b0, t;
    logic [4:0] hl;
    logic [3:0] s;
    send(16'hFE00, 5'd7, 8'h00, 4'd0, 1'b0);
    b0 = byte_cnt;
    send(16'h1234, 5'd16, 8'h56, 4'd8, 1'b0);
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    n_tests++;
    if (!in_ready || byte_cnt - b0 != 3) begin
      n_fail++;
      $display("FAIL max_symbol: got %0d bytes before in_ready=%b, required 3 and 1", byte_cnt - b0, in_ready);
    end
    @(posedge clk); #1;
    bp_stop = 1'b0;
    fork
      begin
        for (int k = 0; k < 3000; k++) begin
          hl = 5'($urandom_range(0, 16));
          s  = 4'($urandom_range(0, 8));
          send(16'($urandom), hl, 8'($urandom), s, 1'b0);
        end
        bp_stop = 1'b1;
      end
      begin
        while (!bp_stop) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    send(16'h0000, 5'd0, 8'h00, 4'd0, 1'b1);
    drain("random");
  endtask

  task automatic test_reset_in_stuff();
    send(16'hFF00, 5'd8, 8'h00, 4'd0, 1'b0);
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL stuff_state: got valid=%b byte=%02h, required 1 00", out_valid, out_byte);
    end
    rst = 1'b1;
    exp_q.delete(); bq.delete();
    @(posedge clk); #1;
    n_tests += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_stuff out_valid: got %b, required 0", out_valid); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_stuff in_ready: got %b, required 1", in_ready); end
    rst = 1'b0;
    send(16'hC000, 5'd2, 8'h00, 4'd0, 1'b1);
    drain("after_reset");
  endtask

  initial begin
    rst = 1'b1;
    fork monitor(); join_none
    test_reset();
    test_exact_byte();
    test_stuff_then_pad();
    test_pad_to_ff();
    test_empty_scan();
    test_backpressure();
    test_max_symbol_random();
    test_reset_in_stuff();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
